// File: rtl/dsp_ctrl_pkg.sv
// Shared state encoding and DSP-slice OPMODE codes for the dsp_mac_seq sequencer.
package dsp_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    DRAIN  = 2'd2,
    RESULT = 2'd3
  } state_t;

  localparam logic [7:0] OPM_LOAD = 8'h01;
  localparam logic [7:0] OPM_ACC  = 8'h09;
  localparam logic [7:0] OPM_HOLD = 8'h08;

  // Bit 7 turns the slice post-adder into Z - (X+Y); carry-in bits 4..6 stay 0.
  function automatic logic [7:0] opm_with_sign(input logic [7:0] code, input logic neg);
    logic [7:0] r;
    r    = code;
    r[7] = neg;
    return r;
  endfunction

endpackage

// File: rtl/dsp_mac_seq_if.sv
// Host-side bundle of dsp_mac_seq: command, operand stream and result handshake.
interface dsp_mac_seq_if #(
  parameter int LEN_W = 8
);
  logic                    start;
  logic [LEN_W-1:0]        len;
  logic                    busy;
  logic                    in_valid;
  logic                    in_ready;
  logic signed [17:0]      in_a;
  logic signed [17:0]      in_b;
  logic                    res_valid;
  logic                    res_ready;
  logic [47:0]             res_data;

  modport master (
    output start, len, in_valid, in_a, in_b, res_ready,
    input  busy, in_ready, res_valid, res_data
  );

  modport slave (
    input  start, len, in_valid, in_a, in_b, res_ready,
    output busy, in_ready, res_valid, res_data
  );
endinterface

// File: rtl/dsp_tag_pipe.sv
// Delay line that aligns each OPMODE code with its operands inside the DSP slice.
module dsp_tag_pipe
  import dsp_ctrl_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] code_i,
  output logic [7:0] code_o
);

  logic [7:0] stage_q [DEPTH];

  // Reset refills every stage with HOLD so abandoned codes never reach the slice.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= OPM_HOLD;
    end else begin
      stage_q[0] <= code_i;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign code_o = stage_q[DEPTH-1];

endmodule

// File: rtl/dsp_mac_seq.sv
// Dot-product sequencer feeding an external DSP slice (A1/B1/M/OPMODE regs = 1).
// Optional feature: define DSP_MAC_SUB_EN to add the `sub` port (P = 0 - sum(A*B)).
module dsp_mac_seq
  import dsp_ctrl_pkg::*;
#(
  parameter int OPM_DLY = 2,
  parameter int LEN_W   = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  dsp_mac_seq_if.slave host,
  output logic [17:0]  dsp_a,
  output logic [17:0]  dsp_b,
  output logic [7:0]   dsp_opmode,
  input  logic [47:0]  dsp_p
`ifdef DSP_MAC_SUB_EN
  ,
  input  logic         sub
`endif
);

  localparam int DRN_W = $clog2(OPM_DLY + 1);

  state_t           state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             sub_q, sub_d;
  logic [DRN_W-1:0] drn_q, drn_d;
  logic [17:0]      a_q, b_q;
  logic             accept_s, last_s, sub_in_s;
  logic [7:0]       code_s;

`ifdef DSP_MAC_SUB_EN
  assign sub_in_s = sub;
`else
  assign sub_in_s = 1'b0;
`endif

  assign accept_s = (state_q == RUN) && host.in_valid;
  assign last_s   = accept_s && ((cnt_q + LEN_W'(1)) == len_q);

  // Next-state: DRAIN lasts OPM_DLY+1 cycles so the final product has left P.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    sub_d   = sub_q;
    drn_d   = drn_q;
    case (state_q)
      IDLE: begin
        if (host.start && (host.len != '0)) begin
          state_d = RUN;
          len_d   = host.len;
          cnt_d   = '0;
          sub_d   = sub_in_s;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (accept_s) begin
          cnt_d = cnt_q + LEN_W'(1);
          if (last_s) begin
            state_d = DRAIN;
            drn_d   = '0;
          end else begin
            state_d = RUN;
          end
        end else begin
          state_d = RUN;
        end
      end
      DRAIN: begin
        if (drn_q == DRN_W'(OPM_DLY)) begin
          state_d = RESULT;
        end else begin
          drn_d = drn_q + DRN_W'(1);
        end
      end
      RESULT: begin
        if (host.res_ready) begin
          state_d = IDLE;
        end else begin
          state_d = RESULT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Code entering the delay line: LOAD/ACC on acceptance, HOLD on every other cycle.
  always_comb begin
    if (accept_s) begin
      code_s = opm_with_sign((cnt_q == '0) ? OPM_LOAD : OPM_ACC, sub_q);
    end else if (state_q == IDLE) begin
      code_s = OPM_HOLD;
    end else begin
      code_s = opm_with_sign(OPM_HOLD, sub_q);
    end
  end

  // State, counters and the zero-when-idle operand registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      sub_q   <= 1'b0;
      drn_q   <= '0;
      a_q     <= 18'd0;
      b_q     <= 18'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      sub_q   <= sub_d;
      drn_q   <= drn_d;
      a_q     <= accept_s ? host.in_a : 18'd0;
      b_q     <= accept_s ? host.in_b : 18'd0;
    end
  end

  dsp_tag_pipe #(.DEPTH(OPM_DLY)) u_tag_pipe (
    .clk    (clk),
    .rst_n  (rst_n),
    .code_i (code_s),
    .code_o (dsp_opmode)
  );

  assign dsp_a          = a_q;
  assign dsp_b          = b_q;
  assign host.in_ready  = (state_q == RUN);
  assign host.busy      = (state_q != IDLE);
  assign host.res_valid = (state_q == RESULT);
  assign host.res_data  = (state_q == RESULT) ? dsp_p : 48'd0;

endmodule

// File: tb/tb_dsp_mac_seq.sv
// Bench for dsp_mac_seq: behavioural DSP slice plus per-cycle trace scoreboard.
module tb_dsp_mac_seq;
  localparam int OPM_DLY = 2;
  localparam int MAXC    = 1024;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic [17:0] dsp_a, dsp_b;
  logic [7:0]  dsp_opmode;
  logic [47:0] dsp_p;
`ifdef DSP_MAC_SUB_EN
  logic        sub_r = 1'b0;
`endif

  dsp_mac_seq_if #(.LEN_W(8)) bus ();

  dsp_mac_seq #(.OPM_DLY(OPM_DLY), .LEN_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .host       (bus),
    .dsp_a      (dsp_a),
    .dsp_b      (dsp_b),
    .dsp_opmode (dsp_opmode),
    .dsp_p      (dsp_p)
`ifdef DSP_MAC_SUB_EN
    ,
    .sub        (sub_r)
`endif
  );

  always #5 clk = ~clk;

  // Slice model: A1/B1 -> M, OPMODE reg, then P = Z +/- M with Z = P when bit 3 set.
  logic signed [17:0] a1 = 18'sd0, b1 = 18'sd0;
  logic signed [47:0] m_m = 48'sd0, p_m = 48'sd0, xy_s;
  logic [7:0]         opm_r = 8'h08;
  assign xy_s  = opm_r[0] ? m_m : 48'sd0;
  assign dsp_p = p_m;
  always @(posedge clk) begin
    a1    <= dsp_a;
    b1    <= dsp_b;
    m_m   <= 48'(a1) * 48'(b1);
    opm_r <= dsp_opmode;
    p_m   <= (opm_r[3] ? p_m : 48'sd0) + (opm_r[7] ? -xy_s : xy_s);
  end

  int n_pass = 0, n_total = 0;

  logic signed [17:0] pa [256];
  logic signed [17:0] pb [256];
  bit          vplan [MAXC];
  int          hold_n, cur_len, last_e, rel_e, win;
  bit          poke_start;
  int          acc_e [256];
  logic [7:0]  o_opm [MAXC];
  logic [17:0] o_a [MAXC];
  logic [17:0] o_b [MAXC];
  logic        o_rdy [MAXC];
  logic        o_busy [MAXC];
  logic        o_rv [MAXC];
  logic [47:0] o_rd [MAXC];

  function automatic logic [7:0] exp_opm(input int j);
    for (int k = 0; k < cur_len; k++)
      if (acc_e[k] == j - OPM_DLY) return (k == 0) ? 8'h01 : 8'h09;
    return 8'h08;
  endfunction

  function automatic logic [17:0] exp_a(input int j);
    for (int k = 0; k < cur_len; k++) if (acc_e[k] == j - 1) return pa[k];
    return 18'd0;
  endfunction

  function automatic logic [17:0] exp_b(input int j);
    for (int k = 0; k < cur_len; k++) if (acc_e[k] == j - 1) return pb[k];
    return 18'd0;
  endfunction

  function automatic logic [47:0] exp_sum();
    longint s = 0;
    for (int k = 0; k < cur_len; k++) s += longint'(pa[k]) * longint'(pb[k]);
    return 48'(s);
  endfunction

  task automatic set_plan(input bit all_valid);
    for (int j = 0; j < MAXC; j++) vplan[j] = all_valid;
    hold_n = 0;
    poke_start = 1'b0;
  endtask

  // Drives one job (start in cycle 0) and records every output once per cycle.
  task automatic drive_op(input int len, input bit sb);
    int k;
    k = 0; cur_len = len; last_e = -1; rel_e = MAXC; win = MAXC;
    for (int j = 0; j < MAXC; j++) begin
      @(negedge clk);
      o_opm[j] = dsp_opmode; o_a[j] = dsp_a; o_b[j] = dsp_b; o_rdy[j] = bus.in_ready;
      o_busy[j] = bus.busy; o_rv[j] = bus.res_valid; o_rd[j] = bus.res_data;
      bus.start = 1'b0; bus.len = 8'd0; bus.in_valid = 1'b0;
      bus.in_a = 18'sd0; bus.in_b = 18'sd0; bus.res_ready = 1'b0;
      if (j == 0) begin
        bus.start = 1'b1; bus.len = 8'(len);
`ifdef DSP_MAC_SUB_EN
        sub_r = sb;
`endif
      end else if (k < len && vplan[j]) begin
        bus.in_valid = 1'b1; bus.in_a = pa[k]; bus.in_b = pb[k];
        acc_e[k] = j; k++;
        if (k == len) begin
          last_e = j;
          rel_e  = j + OPM_DLY + 2 + hold_n;
        end
      end
      if (poke_start && last_e >= 0 && j > last_e && j <= rel_e) begin
        bus.start = 1'b1; bus.len = 8'd7;
      end
      if (j == rel_e) bus.res_ready = 1'b1;
      if (j == rel_e + 2) begin
        win = j + 1;
        break;
      end
    end
    if (sb) n_total += 0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0; bus.start = 1'b1; bus.len = 8'd3; bus.in_valid = 1'b1;
    bus.in_a = 18'sd5; bus.in_b = 18'sd6; bus.res_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_total++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy); else n_pass++;
    n_total++; if (bus.in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b want 0", bus.in_ready); else n_pass++;
    n_total++; if (bus.res_valid !== 1'b0) $display("FAIL reset_res_valid: got %b want 0", bus.res_valid); else n_pass++;
    n_total++; if (dsp_a !== 18'd0 || dsp_b !== 18'd0) $display("FAIL reset_dsp_ab: got %h/%h want 0/0", dsp_a, dsp_b); else n_pass++;
    n_total++; if (dsp_opmode !== 8'h08) $display("FAIL reset_opmode: got %h want 08", dsp_opmode); else n_pass++;
    rst_n = 1'b1; bus.start = 1'b0; bus.len = 8'd0; bus.in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    set_plan(1'b1);
    pa[0] = 18'sd2;  pb[0] = 18'sd3;
    pa[1] = 18'sd4;  pb[1] = 18'sd5;
    pa[2] = -18'sd1; pb[2] = 18'sd7;
    drive_op(3, 1'b0);
    n_total++; if (o_rv[last_e+3] !== 1'b0) $display("FAIL b2b_early_valid: got %b want 0", o_rv[last_e+3]); else n_pass++;
    n_total++; if (o_rv[last_e+4] !== 1'b1) $display("FAIL b2b_valid_at_L+4: got %b want 1", o_rv[last_e+4]); else n_pass++;
    n_total++; if (o_rd[last_e+4] !== 48'd19) $display("FAIL b2b_result: got %0d want 19", o_rd[last_e+4]); else n_pass++;
    n_total++; if (o_opm[acc_e[0]+2] !== 8'h01) $display("FAIL b2b_opm_first: got %h want 01", o_opm[acc_e[0]+2]); else n_pass++;
    n_total++; if (o_opm[acc_e[2]+2] !== 8'h09) $display("FAIL b2b_opm_last: got %h want 09", o_opm[acc_e[2]+2]); else n_pass++;
    n_total++; if (o_a[acc_e[1]+1] !== 18'd4) $display("FAIL b2b_dsp_a: got %h want 4", o_a[acc_e[1]+1]); else n_pass++;
    n_total++; if (o_busy[rel_e+1] !== 1'b0) $display("FAIL b2b_idle_after: got %b want 0", o_busy[rel_e+1]); else n_pass++;
  endtask

  task automatic test_gap();
    set_plan(1'b0);
    vplan[1] = 1'b1; vplan[5] = 1'b1;
    pa[0] = 18'sd100; pb[0] = 18'sd100;
    pa[1] = 18'sd1;   pb[1] = 18'sd1;
    drive_op(2, 1'b0);
    n_total++; if (o_rd[last_e+4] !== 48'd10001) $display("FAIL gap_result: got %0d want 10001", o_rd[last_e+4]); else n_pass++;
    for (int j = 4; j <= 6; j++) begin
      n_total++; if (o_opm[j] !== 8'h08) $display("FAIL gap_opm_hold c%0d: got %h want 08", j, o_opm[j]); else n_pass++;
    end
    n_total++; if (o_a[3] !== 18'd0) $display("FAIL gap_dsp_a_zero: got %h want 0", o_a[3]); else n_pass++;
    n_total++; if (o_opm[7] !== 8'h09) $display("FAIL gap_opm_acc: got %h want 09", o_opm[7]); else n_pass++;
  endtask

  task automatic test_backpressure();
    set_plan(1'b1);
    hold_n = 5; poke_start = 1'b1;
    pa[0] = 18'sd2;  pb[0] = 18'sd3;
    pa[1] = 18'sd4;  pb[1] = 18'sd5;
    pa[2] = -18'sd1; pb[2] = 18'sd7;
    drive_op(3, 1'b0);
    for (int j = last_e + 4; j <= rel_e; j++) begin
      n_total++; if (o_rd[j] !== 48'd19) $display("FAIL bp_hold_data c%0d: got %0d want 19", j, o_rd[j]); else n_pass++;
      n_total++; if (o_rv[j] !== 1'b1 || o_rdy[j] !== 1'b0) $display("FAIL bp_hold_flags c%0d: got v%b r%b want v1 r0", j, o_rv[j], o_rdy[j]); else n_pass++;
    end
    n_total++; if (o_opm[last_e+5] !== 8'h08) $display("FAIL bp_result_opm: got %h want 08", o_opm[last_e+5]); else n_pass++;
    n_total++; if (o_busy[rel_e+1] !== 1'b0 || o_busy[rel_e+2] !== 1'b0) $display("FAIL bp_start_ignored: got %b%b want 00", o_busy[rel_e+1], o_busy[rel_e+2]); else n_pass++;
  endtask

  task automatic test_max_len();
    set_plan(1'b1);
    for (int k = 0; k < 255; k++) begin pa[k] = -18'sd131072; pb[k] = -18'sd131072; end
    drive_op(255, 1'b0);
    n_total++; if (o_rd[last_e+4] !== 48'd4380866641920) $display("FAIL max_len_result: got %0d want 4380866641920", o_rd[last_e+4]); else n_pass++;
    n_total++; if (o_rdy[last_e] !== 1'b1 || o_rdy[last_e+1] !== 1'b0) $display("FAIL max_len_ready_edge: got %b%b want 10", o_rdy[last_e], o_rdy[last_e+1]); else n_pass++;
    @(negedge clk);
    bus.start = 1'b1; bus.len = 8'd0;
    @(negedge clk);
    bus.start = 1'b0;
    for (int j = 0; j < 3; j++) begin
      n_total++; if (bus.busy !== 1'b0 || bus.in_ready !== 1'b0) $display("FAIL zero_len_busy c%0d: got b%b r%b want b0 r0", j, bus.busy, bus.in_ready); else n_pass++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    bus.start = 1'b1; bus.len = 8'd5;
    @(negedge clk);
    bus.start = 1'b0; bus.in_valid = 1'b1; bus.in_a = 18'sd7; bus.in_b = 18'sd7;
    @(negedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    n_total++; if (bus.busy !== 1'b1 || dsp_opmode !== 8'h01) $display("FAIL rstmid_before: got b%b opm %h want b1 opm 01", bus.busy, dsp_opmode); else n_pass++;
    rst_n = 1'b0;
    @(negedge clk);
    n_total++; if (bus.busy !== 1'b0) $display("FAIL rstmid_busy: got %b want 0", bus.busy); else n_pass++;
    n_total++; if (dsp_opmode !== 8'h08) $display("FAIL rstmid_opmode: got %h want 08", dsp_opmode); else n_pass++;
    rst_n = 1'b1;
    set_plan(1'b1);
    pa[0] = 18'sd3; pb[0] = 18'sd3;
    drive_op(1, 1'b0);
    n_total++; if (o_rd[last_e+4] !== 48'd9) $display("FAIL rstmid_rerun: got %0d want 9", o_rd[last_e+4]); else n_pass++;
  endtask

  task automatic test_random();
    logic [7:0] e_opm;
    bit e_rdy, e_busy, e_rv;
    for (int it = 0; it < 6; it++) begin
      set_plan(1'b0);
      for (int j = 1; j < MAXC; j++) vplan[j] = ($urandom_range(0, 3) != 0);
      hold_n = $urandom_range(0, 3);
      poke_start = bit'($urandom_range(0, 1));
      cur_len = $urandom_range(1, 12);
      for (int k = 0; k < cur_len; k++) begin
        pa[k] = 18'($urandom_range(0, 262143));
        pb[k] = 18'($urandom_range(0, 262143));
      end
      drive_op(cur_len, 1'b0);
      for (int j = 0; j < win; j++) begin
        e_rdy = (j >= 1 && j <= last_e);
        e_busy = (j >= 1 && j <= rel_e);
        e_rv = (j >= last_e + OPM_DLY + 2 && j <= rel_e);
        e_opm = exp_opm(j);
        n_total++; if (o_rdy[j] !== e_rdy) $display("FAIL rnd%0d_in_ready c%0d: got %b want %b", it, j, o_rdy[j], e_rdy); else n_pass++;
        n_total++; if (o_busy[j] !== e_busy) $display("FAIL rnd%0d_busy c%0d: got %b want %b", it, j, o_busy[j], e_busy); else n_pass++;
        n_total++; if (o_rv[j] !== e_rv) $display("FAIL rnd%0d_res_valid c%0d: got %b want %b", it, j, o_rv[j], e_rv); else n_pass++;
        n_total++; if (o_opm[j] !== e_opm) $display("FAIL rnd%0d_opmode c%0d: got %h want %h", it, j, o_opm[j], e_opm); else n_pass++;
        n_total++; if (o_a[j] !== exp_a(j) || o_b[j] !== exp_b(j)) $display("FAIL rnd%0d_dsp_ab c%0d: got %h/%h want %h/%h", it, j, o_a[j], o_b[j], exp_a(j), exp_b(j)); else n_pass++;
        if (e_rv) begin
          n_total++; if (o_rd[j] !== exp_sum()) $display("FAIL rnd%0d_res_data c%0d: got %h want %h", it, j, o_rd[j], exp_sum()); else n_pass++;
        end
      end
    end
  endtask

`ifdef DSP_MAC_SUB_EN
  task automatic test_sub();
    set_plan(1'b1);
    pa[0] = 18'sd2; pb[0] = 18'sd3;
    pa[1] = 18'sd4; pb[1] = 18'sd5;
    drive_op(2, 1'b1);
    n_total++; if (o_rd[last_e+4] !== 48'hFFFFFFFFFFE6) $display("FAIL sub_result: got %h want FFFFFFFFFFE6", o_rd[last_e+4]); else n_pass++;
    n_total++; if (o_opm[acc_e[0]+2] !== 8'h81 || o_opm[acc_e[1]+2] !== 8'h89) $display("FAIL sub_opm: got %h/%h want 81/89", o_opm[acc_e[0]+2], o_opm[acc_e[1]+2]); else n_pass++;
  endtask
`endif

  initial begin
    bus.start = 1'b0; bus.len = 8'd0; bus.in_valid = 1'b0;
    bus.in_a = 18'sd0; bus.in_b = 18'sd0; bus.res_ready = 1'b0;
    test_reset();
    test_back_to_back();
    test_gap();
    test_backpressure();
    test_max_len();
    test_reset_mid();
    test_random();
`ifdef DSP_MAC_SUB_EN
    test_sub();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/dsp_mac_seq.md
DSP_MAC_SEQ -- requirements
Module: dsp_mac_seq

Interface
REQ-001 Parameter OPM_DLY, default 2, SHALL set the cycles from operand acceptance until `dsp_opmode` carries that sample's code; it matches slice A1REG/B1REG/MREG/OPMODEREG = 1.
REQ-002 Parameter LEN_W, default 8, SHALL set the width of `len`.
REQ-003 `clk` SHALL be an input, 1 bit wide, and the sole clock; all logic is on its rising edge.
REQ-004 `rst_n` SHALL be an input, 1 bit wide, synchronous, active-low reset.
REQ-005 `start` SHALL be an input, 1 bit wide, requesting a new dot-product.
REQ-006 `len` SHALL be an input, LEN_W bits wide, giving the number of operand pairs; it is sampled on accepted `start`.
REQ-007 `busy` SHALL be an output, 1 bit wide, high whenever state != IDLE.
REQ-008 `in_valid` / `in_ready` SHALL be an input / output, 1 bit each, forming the operand handshake.
REQ-009 `in_a` and `in_b` SHALL each be an input, 18 bits wide, signed operands.
REQ-010 `dsp_a` and `dsp_b` SHALL each be an output, 18 bits wide, registered, driving slice A and B.
REQ-011 `dsp_opmode` SHALL be an output, 8 bits wide, registered, driving slice OPMODE.
REQ-012 `dsp_p` SHALL be an input, 48 bits wide, from slice P.
REQ-013 `res_valid` / `res_ready` SHALL be an output / input, 1 bit each, forming the result handshake.
REQ-014 `res_data` SHALL be an output, 48 bits wide, equal to `dsp_p` while `res_valid` is high.

Function
REQ-015 The block SHALL use FSM states IDLE, RUN, DRAIN and RESULT.
REQ-016 IDLE -> RUN SHALL occur on `start` with `len` != 0; `start` with `len` == 0, and `start` outside IDLE, SHALL be ignored.
REQ-017 In RUN, `in_ready` SHALL be 1 until `len` pairs are accepted; it SHALL be 0 in all other states.
REQ-018 An accepted pair at cycle t SHALL appear on `dsp_a`/`dsp_b` at t+1; in cycles with no acceptance, `dsp_a`/`dsp_b` SHALL be 0.
REQ-019 The opmode code for the pair accepted at t SHALL appear on `dsp_opmode` at t+OPM_DLY:
  - 8'h01 (P=M) for the first pair;
  - 8'h09 (P=P+M) for later pairs.
REQ-020 Every cycle with no sample code due SHALL drive 8'h08 (P=P+0, hold). Gaps in `in_valid` SHALL therefore not disturb the accumulator.
REQ-021 RUN -> DRAIN SHALL occur on the last acceptance.
REQ-022 DRAIN -> RESULT SHALL occur so that `res_valid` rises at last-accept + OPM_DLY + 2 (cycle 6 for last accept at cycle 2, default).
REQ-023 In RESULT, `res_valid` SHALL be 1 and `dsp_opmode` SHALL be 8'h08; `res_data` SHALL be stable until `res_ready`.
REQ-024 The handshake (`res_valid` && `res_ready`) SHALL return the FSM to IDLE the next cycle; `start` in that same cycle SHALL be ignored.
REQ-025 The internal pair counter SHALL be LEN_W bits and SHALL not wrap; the maximum length is 2^LEN_W-1.
REQ-026 Carry-in SHALL be 0: opmode bit 5 is always 0, and bits 4 and 6 are 0.

Reset
REQ-027 When `rst_n`=0 at a clock edge, the block SHALL enter IDLE and set the counter to 0.
REQ-028 Under reset: `dsp_a`=0, `dsp_b`=0, `dsp_opmode`=8'h08, `in_ready`=0, `res_valid`=0, `busy`=0.
REQ-029 A reset mid-RUN/DRAIN/RESULT SHALL abandon the operation; in-flight opmode codes SHALL be cleared.

Configuration
REQ-030 With DSP_MAC_SUB_EN defined:
  - input `sub` (1 bit) SHALL be sampled on accepted `start`;
  - if 1, every code from REQ-019 and REQ-020 SHALL have bit 7 set (8'h81, 8'h89, 8'h88), giving P = 0 - sum(A*B).
REQ-031 Without DSP_MAC_SUB_EN, port `sub` SHALL not exist and bit 7 SHALL always be 0.

Structure
REQ-032 Package dsp_ctrl_pkg SHALL hold the state enum and the constants OPM_LOAD=8'h01, OPM_ACC=8'h09 and OPM_HOLD=8'h08.
REQ-033 Sub-module dsp_tag_pipe SHALL implement the OPM_DLY-deep opmode shift register (reset-clearable, filling with OPM_HOLD).

Verification
REQ-034 len=3, pairs (2,3),(4,5),(-1,7) back-to-back -> `res_data`=19; `res_valid` at last-accept+4.
REQ-035 len=2, pairs (100,100), then a 3-cycle `in_valid` gap, then (1,1) -> `res_data`=10001; `dsp_opmode`=8'h08 during the gap.
REQ-036 len=3 result with `res_ready` low for 5 cycles -> `res_data` holds 19, `in_ready`=0, `start` ignored; IDLE follows the handshake.
REQ-037 len=255, all pairs (-131072,-131072) -> `res_data`=4380866641920 (no overflow); len=0 start -> `busy` stays 0.
REQ-038 `rst_n`=0 after 2 of 5 accepts -> next cycle `busy`=0, `dsp_opmode`=8'h08; a new len=1 (3,3) run -> 9.
REQ-039 With DSP_MAC_SUB_EN: `sub`=1, len=2, (2,3),(4,5) -> `res_data`=-26 (48'hFFFFFFFFFFE6).
